mc_cu: RTL and testbench

MC_CU -- requirements
Module: mc_cu

---
 rtl/mc_cu.sv | 229 ++++++++++++++++++++++
 tb/tb_mc_cu.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_cu.sv
// mc_cu: multi-cycle control unit for an RV32I-style datapath.
// Optional feature: define CU_TIMEOUT_EN to add a TO_W-bit memory-wait
// timeout that traps when a fetch or data access is never acknowledged.
// Handshake: a request (imem_req/dmem_req) stays high from the start of its
// state until the matching ack is sampled high on a rising clk edge; an ack
// seen while its request is low has no effect.
module mc_cu #(
  parameter int AOP_W = 4,
  parameter int TO_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode_i_cu,
  input  logic [2:0]       func3_i_cu,
  input  logic [6:0]       func7_i_cu,
  input  logic             jb_i_cu,
  input  logic             imem_ack_i_cu,
  input  logic             dmem_ack_i_cu,
  output logic             imem_req_o_cu,
  output logic             dmem_req_o_cu,
  output logic             dmem_wr_o_cu,
  output logic [AOP_W-1:0] aluop_o_cu,
  output logic [1:0]       opsel_o_cu,
  output logic [2:0]       immsel_o_cu,
  output logic             re1_o_cu,
  output logic             re2_o_cu,
  output logic             we_o_cu,
  output logic             pcsel_o_cu,
  output logic             pc_we_o_cu,
  output logic             ir_we_o_cu,
  output logic             halt_o_cu,
  output logic             illegal_o_cu,
  output logic             timeout_o_cu,
  output logic [2:0]       state_o_cu
);

  if (AOP_W < 4 || TO_W < 1) begin : g_param_chk
    $error("mc_cu: AOP_W must be >= 4 and TO_W >= 1");
  end

  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3,
    S_WB = 3'd4, S_HALT = 3'd5, S_TRAP = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [6:0]       opc_q, opc_d, f7_q, f7_d;
  logic [2:0]       f3_q, f3_d;
  logic             imem_req_q, imem_req_d, dmem_req_q, dmem_req_d;
  logic             dmem_wr_q, dmem_wr_d, re1_q, re1_d, re2_q, re2_d;
  logic             we_q, we_d, pc_we_q, pc_we_d, pcsel_q, pcsel_d;
  logic             halt_q, halt_d, illegal_q, illegal_d;
  logic [AOP_W-1:0] aluop_q, aluop_d;
  logic [1:0]       opsel_q, opsel_d;
  logic [2:0]       immsel_q, immsel_d;

  logic       dec_legal, dec_halt, dec_re1, dec_re2, dec_mem, dec_store;
  logic       dec_wb, dec_jump, dec_branch, ex_pcsel, ir_load, to_fire;
  logic [3:0] dec_alu;
  logic [1:0] dec_opsel;
  logic [2:0] dec_imm;

  // Instruction fields are captured on the fetch ack edge, so decode looks
  // at the value the IR will hold from the next cycle on.
  assign ir_load = imem_req_q & imem_ack_i_cu;
  assign opc_d   = ir_load ? opcode_i_cu : opc_q;
  assign f3_d    = ir_load ? func3_i_cu  : f3_q;
  assign f7_d    = ir_load ? func7_i_cu  : f7_q;

  // Decode the (next) IR contents into the internal control word.
  always_comb begin
    dec_legal = 1'b1; dec_halt = 1'b0; dec_re1 = 1'b0; dec_re2 = 1'b0;
    dec_mem = 1'b0; dec_store = 1'b0; dec_wb = 1'b0; dec_jump = 1'b0;
    dec_branch = 1'b0; dec_alu = 4'd0; dec_opsel = 2'b00; dec_imm = 3'd0;
    case (opc_d)
      7'b0010011, 7'b0110011: begin
        dec_re1 = 1'b1;
        dec_wb  = 1'b1;
        case (f3_d)
          3'b000:  dec_alu = (opc_d[5] && f7_d[5]) ? 4'd1 : 4'd0;
          3'b001:  dec_alu = 4'd7;
          3'b010:  dec_alu = 4'd5;
          3'b011:  dec_alu = 4'd6;
          3'b100:  dec_alu = 4'd4;
          3'b101:  dec_alu = f7_d[5] ? 4'd9 : 4'd8;
          3'b110:  dec_alu = 4'd3;
          default: dec_alu = 4'd2;
        endcase
        if (opc_d[5]) begin
          dec_re2   = 1'b1;
          dec_opsel = 2'b01;
          dec_legal = (f7_d == 7'h00) ||
                      (f7_d == 7'h20 && (f3_d == 3'b000 || f3_d == 3'b101));
        end else if (f3_d == 3'b001) begin
          dec_legal = (f7_d == 7'h00);
        end else if (f3_d == 3'b101) begin
          dec_legal = (f7_d == 7'h00) || (f7_d == 7'h20);
        end
      end
      7'b0110111: begin dec_alu = 4'd10; dec_imm = 3'd3; dec_wb = 1'b1; end
      7'b0010111: begin dec_opsel = 2'b10; dec_imm = 3'd3; dec_wb = 1'b1; end
      7'b1101111: begin
        dec_opsel = 2'b11; dec_imm = 3'd4; dec_wb = 1'b1; dec_jump = 1'b1;
      end
      7'b1100111: begin
        dec_re1 = 1'b1; dec_opsel = 2'b11; dec_wb = 1'b1; dec_jump = 1'b1;
        dec_legal = (f3_d == 3'b000);
      end
      7'b1100011: begin
        dec_re1 = 1'b1; dec_re2 = 1'b1; dec_opsel = 2'b10; dec_imm = 3'd2;
        dec_branch = 1'b1;
        dec_legal  = (f3_d != 3'b010) && (f3_d != 3'b011);
      end
      7'b0000011: begin
        dec_re1 = 1'b1; dec_mem = 1'b1; dec_wb = 1'b1;
        dec_legal = (f3_d != 3'b011) && (f3_d[2:1] != 2'b11);
      end
      7'b0100011: begin
        dec_re1 = 1'b1; dec_re2 = 1'b1; dec_imm = 3'd1; dec_mem = 1'b1;
        dec_store = 1'b1;
        dec_legal = (f3_d[2] == 1'b0) && (f3_d != 3'b011);
      end
      7'b1110011: begin dec_legal = 1'b0; dec_halt = (f3_d == 3'b000); end
      default:    dec_legal = 1'b0;
    endcase
  end

  // The PC mux follows the live branch compare in EX; WB replays that value.
  assign ex_pcsel = dec_jump | (dec_branch & jb_i_cu);

  // Next state plus registered outputs computed from the state being entered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:    if (ir_load) state_d = S_ID;
      S_ID:    state_d = dec_halt ? S_HALT : (dec_legal ? S_EX : S_TRAP);
      S_EX:    state_d = dec_mem ? S_MEM : S_WB;
      S_MEM:   if (dmem_req_q && dmem_ack_i_cu) state_d = S_WB;
      S_WB:    state_d = S_IF;
      S_HALT:  state_d = S_HALT;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
    if (to_fire) state_d = S_TRAP;

    imem_req_d = (state_d == S_IF);
    re1_d      = (state_d == S_ID) && dec_legal && dec_re1;
    re2_d      = (state_d == S_ID) && dec_legal && dec_re2;
    aluop_d    = (state_d == S_EX) ? AOP_W'(dec_alu) : '0;
    opsel_d    = (state_d == S_EX) ? dec_opsel : 2'b00;
    immsel_d   = (state_d == S_EX) ? dec_imm : 3'd0;
    dmem_req_d = (state_d == S_MEM);
    dmem_wr_d  = (state_d == S_MEM) && dec_store;
    we_d       = (state_d == S_WB) && dec_wb;
    pc_we_d    = (state_d == S_WB);
    pcsel_d    = (state_d == S_WB) && ((state_q == S_EX) ? ex_pcsel : pcsel_q);
    halt_d     = (state_d == S_HALT);
    illegal_d  = (state_d == S_TRAP);
  end

  // Single state/output register bank; reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IF; opc_q <= '0; f3_q <= '0; f7_q <= '0;
      imem_req_q <= 1'b0; dmem_req_q <= 1'b0; dmem_wr_q <= 1'b0;
      re1_q <= 1'b0; re2_q <= 1'b0; we_q <= 1'b0; pc_we_q <= 1'b0;
      pcsel_q <= 1'b0; halt_q <= 1'b0; illegal_q <= 1'b0;
      aluop_q <= '0; opsel_q <= '0; immsel_q <= '0;
    end else begin
      state_q <= state_d; opc_q <= opc_d; f3_q <= f3_d; f7_q <= f7_d;
      imem_req_q <= imem_req_d; dmem_req_q <= dmem_req_d; dmem_wr_q <= dmem_wr_d;
      re1_q <= re1_d; re2_q <= re2_d; we_q <= we_d; pc_we_q <= pc_we_d;
      pcsel_q <= pcsel_d; halt_q <= halt_d; illegal_q <= illegal_d;
      aluop_q <= aluop_d; opsel_q <= opsel_d; immsel_q <= immsel_d;
    end
  end

`ifdef CU_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = {TO_W{1'b1}} - 1'b1;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d, waiting;

  // A waiting cycle is a request-high cycle with no ack; the count reaching
  // all-ones on such a cycle forces TRAP.
  assign waiting = (state_q == S_IF  && imem_req_q && !imem_ack_i_cu) ||
                   (state_q == S_MEM && dmem_req_q && !dmem_ack_i_cu);
  assign to_fire = waiting && (to_cnt_q == TO_LAST);

  // Counter restarts on every entry into a waiting state.
  always_comb begin
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q | to_fire;
    if (state_d != state_q && (state_d == S_IF || state_d == S_MEM)) to_cnt_d = '0;
    else if (waiting) to_cnt_d = to_cnt_q + 1'b1;
  end

  // Timeout counter and sticky flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_o_cu = timeout_q;
`else
  assign to_fire      = 1'b0;
  assign timeout_o_cu = 1'b0;
`endif

  assign state_o_cu    = state_q;
  assign imem_req_o_cu = imem_req_q;
  assign dmem_req_o_cu = dmem_req_q;
  assign dmem_wr_o_cu  = dmem_wr_q;
  assign aluop_o_cu    = aluop_q;
  assign opsel_o_cu    = opsel_q;
  assign immsel_o_cu   = immsel_q;
  assign re1_o_cu      = re1_q;
  assign re2_o_cu      = re2_q;
  assign we_o_cu       = we_q;
  assign pc_we_o_cu    = pc_we_q;
  assign pcsel_o_cu    = (state_q == S_EX) ? ex_pcsel : pcsel_q;
  assign ir_we_o_cu    = ir_load;
  assign halt_o_cu     = halt_q;
  assign illegal_o_cu  = illegal_q;

endmodule

// File: tb/tb_mc_cu.sv
// tb_mc_cu: randomized self-checking bench for mc_cu (AOP_W=4, TO_W=4).
// Each instruction is expanded into an expected per-cycle state sequence and
// every cycle's full output vector is compared against the reference model.
module tb_mc_cu;

  logic       clk, rst;
  logic [6:0] opcode, func7;
  logic [2:0] func3;
  logic       jb, imem_ack, dmem_ack;
  logic       imem_req, dmem_req, dmem_wr, re1, re2, we, pcsel, pc_we, ir_we;
  logic       halt, illegal, timeout;
  logic [3:0] aluop;
  logic [1:0] opsel;
  logic [2:0] immsel, state;
  logic [23:0] obs;

  int n_vec = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];

  mc_cu #(.AOP_W(4), .TO_W(4)) dut (
    .clk(clk), .rst(rst), .opcode_i_cu(opcode), .func3_i_cu(func3),
    .func7_i_cu(func7), .jb_i_cu(jb), .imem_ack_i_cu(imem_ack),
    .dmem_ack_i_cu(dmem_ack), .imem_req_o_cu(imem_req),
    .dmem_req_o_cu(dmem_req), .dmem_wr_o_cu(dmem_wr), .aluop_o_cu(aluop),
    .opsel_o_cu(opsel), .immsel_o_cu(immsel), .re1_o_cu(re1), .re2_o_cu(re2),
    .we_o_cu(we), .pcsel_o_cu(pcsel), .pc_we_o_cu(pc_we), .ir_we_o_cu(ir_we),
    .halt_o_cu(halt), .illegal_o_cu(illegal), .timeout_o_cu(timeout),
    .state_o_cu(state)
  );

  assign obs = {state, imem_req, ir_we, re1, re2, aluop, opsel, immsel, pcsel,
                dmem_req, dmem_wr, we, pc_we, halt, illegal, timeout};

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: architectural meaning of each encoding.
  typedef struct packed {
    logic legal, halt, re1, re2, mem, store, wb, jump, branch;
    logic [3:0] alu;
    logic [1:0] opsel;
    logic [2:0] imm;
  } ref_t;

  // ALU op for func3 = 7..0 (AND OR SRL XOR SLTU SLT SLL ADD); alt (sub/sra) adds 1.
  localparam logic [31:0] ALU_BY_F3 = {4'd2, 4'd3, 4'd8, 4'd4, 4'd6, 4'd5, 4'd7, 4'd0};
  localparam logic [7:0]  BR_OK = 8'b1111_0011;
  localparam logic [7:0]  LD_OK = 8'b0011_0111;
  localparam logic [7:0]  ST_OK = 8'b0000_0111;

  function automatic ref_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7);
    ref_t r;
    int   k;
    logic alt;
    r   = '0;
    k   = 4 * int'(f3);
    alt = 1'b0;
    case (op)
      7'b0010011: begin
        r.legal = !((f3 == 3'd1 && f7 != 7'h00) ||
                    (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20));
        alt = (f3 == 3'd5) && f7[5];
        r.alu = ALU_BY_F3[k +: 4] + 4'(alt);
        r.re1 = 1'b1; r.wb = 1'b1;
      end
      7'b0110011: begin
        r.legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        alt = f7[5] && (f3 == 3'd0 || f3 == 3'd5);
        r.alu = ALU_BY_F3[k +: 4] + 4'(alt);
        r.re1 = 1'b1; r.re2 = 1'b1; r.wb = 1'b1; r.opsel = 2'b01;
      end
      7'b0110111: begin r.legal = 1'b1; r.alu = 4'd10; r.imm = 3'd3; r.wb = 1'b1; end
      7'b0010111: begin r.legal = 1'b1; r.opsel = 2'b10; r.imm = 3'd3; r.wb = 1'b1; end
      7'b1101111: begin
        r.legal = 1'b1; r.opsel = 2'b11; r.imm = 3'd4; r.wb = 1'b1; r.jump = 1'b1;
      end
      7'b1100111: begin
        r.legal = (f3 == 3'd0); r.re1 = 1'b1; r.opsel = 2'b11; r.wb = 1'b1; r.jump = 1'b1;
      end
      7'b1100011: begin
        r.legal = BR_OK[f3]; r.re1 = 1'b1; r.re2 = 1'b1; r.opsel = 2'b10;
        r.imm = 3'd2; r.branch = 1'b1;
      end
      7'b0000011: begin r.legal = LD_OK[f3]; r.re1 = 1'b1; r.mem = 1'b1; r.wb = 1'b1; end
      7'b0100011: begin
        r.legal = ST_OK[f3]; r.re1 = 1'b1; r.re2 = 1'b1; r.imm = 3'd1;
        r.mem = 1'b1; r.store = 1'b1;
      end
      7'b1110011: r.halt = (f3 == 3'd0);
      default: r.legal = 1'b0;
    endcase
    if (!r.legal) begin r.re1 = 1'b0; r.re2 = 1'b0; end
    return r;
  endfunction

  // Expected output vector for one cycle spent in state s.
  function automatic logic [23:0] exp_vec(input logic [2:0] s, input logic ack,
                                          input ref_t d, input logic jbv);
    logic ireq, irwe, r1, r2, pcs, dreq, dwr, wen, pcwe, hl, il, taken;
    logic [3:0] alu;
    logic [1:0] os;
    logic [2:0] im;
    {ireq, irwe, r1, r2, pcs, dreq, dwr, wen, pcwe, hl, il} = '0;
    alu = '0; os = '0; im = '0;
    taken = d.jump | (d.branch & jbv);
    case (s)
      3'd0: begin ireq = 1'b1; irwe = ack; end
      3'd1: begin r1 = d.re1; r2 = d.re2; end
      3'd2: begin alu = d.alu; os = d.opsel; im = d.imm; pcs = taken; end
      3'd3: begin dreq = 1'b1; dwr = d.store; end
      3'd4: begin wen = d.wb; pcwe = 1'b1; pcs = taken; end
      3'd5: hl = 1'b1;
      3'd6: il = 1'b1;
      default: ;
    endcase
    return {s, ireq, irwe, r1, r2, alu, os, im, pcs, dreq, dwr, wen, pcwe, hl, il, 1'b0};
  endfunction

  // Driver: asynchronous reset mid-cycle, then release on a falling edge.
  task automatic do_reset();
    #3;
    rst = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1;
    #1;
    n_vec++;
    if (obs !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_async: got %h want %h", obs, 24'h0);
    end
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    n_vec++;
    if (obs !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_boot: got %h want %h", obs, 24'h0);
    end
  endtask

  // Driver + scoreboard: runs one instruction, checking every cycle.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic jbv, input int idly,
                           input int ddly, input int abort_n);
    ref_t d;
    logic [3:0] e;
    logic [23:0] expv;
    int n;
    d = ref_decode(op, f3, f7);
    exp_q = {};
    for (int i = 0; i <= idly; i++) exp_q.push_back({(i == idly), 3'd0});
    exp_q.push_back(4'd1);
    if (d.halt) repeat (3) exp_q.push_back(4'd5);
    else if (!d.legal) repeat (3) exp_q.push_back(4'd6);
    else begin
      exp_q.push_back(4'd2);
      if (d.mem) for (int i = 0; i <= ddly; i++) exp_q.push_back({(i == ddly), 3'd3});
      exp_q.push_back(4'd4);
    end
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      opcode   = (e[2:0] == 3'd0) ? op : 7'($urandom);
      func3    = (e[2:0] == 3'd0) ? f3 : 3'($urandom);
      func7    = (e[2:0] == 3'd0) ? f7 : 7'($urandom);
      imem_ack = (e[2:0] == 3'd0) ? e[3] : 1'($urandom);
      dmem_ack = (e[2:0] == 3'd3) ? e[3] : 1'($urandom);
      jb       = (e[2:0] == 3'd2) ? jbv  : 1'($urandom);
      #1;
      expv = exp_vec(e[2:0], e[3], d, jbv);
      n_vec++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL %s cycle %0d: got %h want %h", name, n, obs, expv);
      end
      n++;
      if (abort_n != 0 && n == abort_n) break;
    end
    if ((abort_n != 0) || d.halt || !d.legal) do_reset();
  endtask

  task automatic test_reset();
    rst = 1'b0; opcode = '0; func3 = '0; func7 = '0; jb = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();
  endtask

  task automatic test_alu();
    run_instr("addi", 7'b0010011, 3'd0, 7'h00, 1'b0, 0, 0, 0);
    run_instr("sub",  7'b0110011, 3'd0, 7'h20, 1'b0, 0, 0, 0);
    run_instr("add",  7'b0110011, 3'd0, 7'h00, 1'b0, 0, 0, 0);
    run_instr("srai", 7'b0010011, 3'd5, 7'h20, 1'b0, 2, 0, 0);
    run_instr("lui",  7'b0110111, 3'd3, 7'h55, 1'b0, 0, 0, 0);
  endtask

  task automatic test_branch();
    run_instr("beq_taken",   7'b1100011, 3'd0, 7'h00, 1'b1, 0, 0, 0);
    run_instr("beq_untaken", 7'b1100011, 3'd0, 7'h00, 1'b0, 0, 0, 0);
    run_instr("jal",         7'b1101111, 3'd2, 7'h13, 1'b0, 1, 0, 0);
  endtask

  task automatic test_mem();
    run_instr("sw_delay3", 7'b0100011, 3'd2, 7'h00, 1'b0, 0, 3, 0);
    run_instr("lw",        7'b0000011, 3'd2, 7'h00, 1'b0, 0, 0, 0);
    run_instr("lw_rst_mid_mem", 7'b0000011, 3'd2, 7'h00, 1'b0, 0, 6, 6);
    run_instr("sw_rst_mid_mem", 7'b0100011, 3'd0, 7'h00, 1'b0, 1, 5, 6);
  endtask

  task automatic test_trap_halt();
    run_instr("illegal_zero", 7'b0000000, 3'd0, 7'h00, 1'b0, 0, 0, 0);
    run_instr("ebreak",       7'b1110011, 3'd0, 7'h00, 1'b0, 0, 0, 0);
    run_instr("bad_branch",   7'b1100011, 3'd2, 7'h00, 1'b0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [6:0] ops [10] = '{7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111,
                             7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                             7'b0100011, 7'b1110011};
    logic [6:0] op, f7;
    int sel;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 10);
      op  = (sel == 10) ? 7'($urandom) : ops[sel];
      case ($urandom_range(0, 2))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      run_instr("random", op, 3'($urandom), f7, 1'($urandom),
                $urandom_range(0, 4), $urandom_range(0, 5), 0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      run_instr("b2b", (i % 2 == 0) ? 7'b0110011 : 7'b0000011, 3'd0, 7'h00,
                1'b0, 0, 0, 0);
  endtask

  task automatic test_timeout();
    ref_t z;
    logic [23:0] expv;
    int limit;
    z = '0;
`ifdef CU_TIMEOUT_EN
    limit = 15;
`else
    limit = 40;
`endif
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      imem_ack = 1'b0; dmem_ack = 1'($urandom);
      #1;
      expv = exp_vec(3'd0, 1'b0, z, 1'b0);
      n_vec++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL fetch_wait cycle %0d: got %h want %h", i, obs, expv);
      end
    end
`ifdef CU_TIMEOUT_EN
    @(negedge clk);
    #1;
    expv = exp_vec(3'd6, 1'b0, z, 1'b0) | 24'h1;
    n_vec++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL timeout_trap: got %h want %h", obs, expv);
    end
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_mem();
    test_trap_halt();
    test_random();
    test_back_to_back();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
